data_mem_ctrl: RTL and testbench

Parametrised data-memory controller that supersedes the bare single-cycle data memory of the RISC-V top. It adds a req/ready/done handshake with configurable wait states, byte/halfword/word accesses using RV32I load/store `funct3` encodings, and sign/zero extension of loads. It sits between the datapath (address = ALU result, write data = rs2) and a word-organised internal RAM. It is the memory side of the upcoming multicycle/stalling core.

---
 rtl/dmc_pkg.sv | 19 +
 rtl/dmc_lane_fmt.sv | 50 +++++
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmc_pkg.sv
// Shared constants for the data-memory controller: RV32I funct3 access sizes,
// FSM state encoding and wait-counter width.
package dmc_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } dmc_state_t;

endpackage

// File: rtl/dmc_lane_fmt.sv
// Byte-lane formatter: store byte mask + replicated store word, and load
// extraction with sign/zero extension. Purely combinational, no backpressure.
module dmc_lane_fmt
  import dmc_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] load_word
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[7:0];
    case (lane)
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      2'd3:    rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  // Halfwords only look at lane[1]; lane[0] is either ignored or flagged upstream.
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en   = 4'b1111;
    wword     = wdata;
    load_word = rword;
    case (size)
      SZ_B, SZ_BU: begin
        byte_en   = 4'b0001 << lane;
        wword     = {4{wdata[7:0]}};
        load_word = (size == SZ_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      SZ_H, SZ_HU: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wdata[15:0]}};
        load_word = (size == SZ_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: latched req/ready/done access to a word RAM, done WAIT_CYCLES+1 edges after accept;
// ready stays low (requests ignored) until the access ends. DMC_MISALIGN_ERR_EN enables misaligned-access err.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  dmc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      wword;
  logic [31:0]      load_word;
  logic [3:0]       byte_en;
  logic             access;
  logic             misalign;
  logic             unused_addr_hi;

  // Upper address bits fall outside the RAM and wrap silently.
  assign idx            = addr_q[IDX_W+1:2];
  assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W+2];
  assign rword          = mem[idx];
  assign access         = (state == S_WAIT) && (cnt == '0);
  assign err            = err_q;

`ifdef DMC_MISALIGN_ERR_EN
  logic is_b;
  logic is_h;
  assign is_b     = (size_q == SZ_B) || (size_q == SZ_BU);
  assign is_h     = (size_q == SZ_H) || (size_q == SZ_HU);
  assign misalign = (is_h && addr_q[0]) || (!is_b && !is_h && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  dmc_lane_fmt u_lane_fmt (
    .size      (size_q),
    .lane      (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (rword),
    .byte_en   (byte_en),
    .wword     (wword),
    .load_word (load_word)
  );

  // RAM is not reset; an edge that sees rst high must not commit a write.
  always_ff @(posedge clk) begin
    if (access && we_q && !misalign && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      rdata   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_W;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= WAIT_INIT;
            ready   <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            err_q <= misalign;
            state <= S_DONE;
            if (misalign)  rdata <= '0;
            else if (!we_q) rdata <= load_word;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model checked every cycle on a WAIT_CYCLES=2 instance,
// plus directed literal checks on it and on a WAIT_CYCLES=0 instance.
module tb_data_mem_ctrl;
  import dmc_pkg::*;

  localparam int W2    = 2;
  localparam int DEPTH = 64;

  logic        clk, rst;
  logic        req2, req0, we;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        rdy2, done2, err2, rdy0, done0, err0;
  logic [31:0] rd2, rd0;

  int tests = 0;
  int fails = 0;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .ready(rdy2), .done(done2), .rdata(rd2), .err(err2));

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .ready(rdy0), .done(done0), .rdata(rd0), .err(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle arithmetic for handshake timing, byte array for memory.
  logic [7:0]  mb [DEPTH*4];
  logic        m_ready = 1'b1;
  logic        m_done  = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_rdata = '0;
  int          cyc = 0, done_at = 0, ready_at = 0;
  bit          pend = 0;
  logic        p_we;
  logic [2:0]  p_sz;
  logic [31:0] p_addr, p_wd;

  task automatic model_access();
    int base, off, nb;
    bit is_b, is_h, mis;
    logic [31:0] v;
    is_b = (p_sz == SZ_B) || (p_sz == SZ_BU);
    is_h = (p_sz == SZ_H) || (p_sz == SZ_HU);
    nb   = is_b ? 1 : (is_h ? 2 : 4);
    base = ((p_addr >> 2) % DEPTH) * 4;
    off  = is_b ? int'(p_addr[1:0]) : (is_h ? (p_addr[1] ? 2 : 0) : 0);
    mis  = 0;
`ifdef DMC_MISALIGN_ERR_EN
    mis = (is_h && p_addr[0]) || (!is_b && !is_h && (p_addr[1:0] != 2'b00));
`endif
    if (mis) begin
      m_err   = 1'b1;
      m_rdata = '0;
    end else if (p_we) begin
      for (int i = 0; i < nb; i++) mb[base+off+i] = p_wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+off+i];
      if (p_sz == SZ_B) v = {{24{v[7]}}, v[7:0]};
      if (p_sz == SZ_H) v = {{16{v[15]}}, v[15:0]};
      m_rdata = v;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_rdata = '0; pend = 0;
    end else begin
      cyc++;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (pend && cyc == done_at) begin
        model_access();
        m_done = 1'b1;
      end
      if (pend && cyc == ready_at) begin
        m_ready = 1'b1;
        pend    = 0;
      end else if (m_ready && req2) begin
        p_we = we; p_sz = size; p_addr = addr; p_wd = wdata;
        m_ready  = 1'b0;
        pend     = 1;
        done_at  = cyc + W2 + 1;
        ready_at = cyc + W2 + 2;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", {31'b0, rdy2}, {31'b0, m_ready});
    chk("done", {31'b0, done2}, {31'b0, m_done});
    chk("rdata", rd2, m_rdata);
    chk("err", {31'b0, err2}, {31'b0, m_err});
  end

  // Issues one access, scrambles the inputs right after acceptance, checks latency.
  task automatic access(input bit fast, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n, lat;
    @(negedge clk);
    we = w; size = sz; addr = a; wdata = wd;
    if (fast) req0 = 1'b1; else req2 = 1'b1;
    n = 0;
    while (!(fast ? rdy0 : rdy2) && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    we = ~w; size = SZ_B; addr = ~a; wdata = ~wd;
    lat = 0;
    forever begin
      @(negedge clk);
      if ((fast ? done0 : done2) || lat > 40) break;
      lat++;
    end
    chk(fast ? "latency_w0" : "latency_w2", lat, fast ? 1 : W2 + 1);
    rd = fast ? rd0 : rd2;
    e  = fast ? err0 : err2;
  endtask

  logic [31:0] rd;
  logic        e;
  int          ndone;

  initial begin
    rst = 1'b1; req2 = 0; req0 = 0; we = 0; size = SZ_W; addr = 0; wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, rdy2}, 32'd1);
    chk("rst_done", {31'b0, done2}, 32'd0);
    chk("rst_rdata", rd2, 32'h0);
    chk("rst_err", {31'b0, err2}, 32'd0);
    chk("rst_ready_w0", {31'b0, rdy0}, 32'd1);
    #2 rst = 1'b0;

    access(0, 1, SZ_W, 32'h10, 32'hDEADBEEF, rd, e);
    access(0, 0, SZ_W, 32'h10, 32'h0, rd, e);
    chk("lw_10", rd, 32'hDEADBEEF);

    // Reset during WAIT of a store: no write, no done.
    @(negedge clk);
    we = 1; size = SZ_W; addr = 32'h10; wdata = 32'h11111111; req2 = 1;
    for (int k = 0; k < 40 && !rdy2; k++) @(negedge clk);
    @(posedge clk); #1 req2 = 0;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (done2) ndone++; end
    chk("rst_wait_no_done", ndone, 0);
    access(0, 0, SZ_W, 32'h10, 32'h0, rd, e);
    chk("rst_wait_word_kept", rd, 32'hDEADBEEF);

    access(0, 1, SZ_B, 32'h11, 32'h55, rd, e);
    chk("store_keeps_rdata", rd, 32'hDEADBEEF);
    access(0, 0, SZ_W, 32'h10, 32'h0, rd, e);
    chk("sb_then_lw", rd, 32'hDEAD55EF);
    access(0, 0, SZ_B, 32'h13, 32'h0, rd, e);
    chk("lb_13", rd, 32'hFFFFFFDE);
    access(0, 0, SZ_BU, 32'h13, 32'h0, rd, e);
    chk("lbu_13", rd, 32'h000000DE);
    access(0, 0, SZ_H, 32'h12, 32'h0, rd, e);
    chk("lh_12", rd, 32'hFFFFDEAD);
    access(0, 0, SZ_HU, 32'h12, 32'h0, rd, e);
    chk("lhu_12", rd, 32'h0000DEAD);
    access(0, 0, SZ_B, 32'h11, 32'h0, rd, e);
    chk("lb_11", rd, 32'h00000055);

    // req held high while busy must not start a second access.
    @(negedge clk);
    we = 0; size = SZ_BU; addr = 32'h13; req2 = 1;
    for (int k = 0; k < 40 && !rdy2; k++) @(negedge clk);
    @(posedge clk); #1;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done2) ndone++;
      if (k == W2 + 1) req2 = 0;
    end
    chk("busy_one_done", ndone, 1);
    chk("busy_rdata", rd2, 32'h000000DE);

    access(0, 1, SZ_H, 32'h12, 32'hBEEF, rd, e);
    access(0, 0, SZ_W, 32'h10, 32'h0, rd, e);
    chk("sh_then_lw", rd, 32'hBEEF55EF);

    access(0, 1, SZ_W, 32'h100, 32'h12345678, rd, e);
    access(0, 0, SZ_W, 32'h0, 32'h0, rd, e);
    chk("wrap_lw_0", rd, 32'h12345678);

`ifdef DMC_MISALIGN_ERR_EN
    access(0, 0, SZ_W, 32'h02, 32'h0, rd, e);
    chk("mis_lw_err", {31'b0, e}, 32'd1);
    chk("mis_lw_rdata", rd, 32'h0);
    access(0, 1, SZ_H, 32'h01, 32'hAAAA, rd, e);
    chk("mis_sh_err", {31'b0, e}, 32'd1);
    access(0, 0, SZ_W, 32'h0, 32'h0, rd, e);
    chk("mis_sh_unchanged", rd, 32'h12345678);
    chk("aligned_err0", {31'b0, e}, 32'd0);
`else
    access(0, 0, SZ_W, 32'h02, 32'h0, rd, e);
    chk("lw_02_aligned_down", rd, 32'h12345678);
    chk("lw_02_err0", {31'b0, e}, 32'd0);
    access(0, 1, SZ_H, 32'h01, 32'hAAAA, rd, e);
    access(0, 0, SZ_W, 32'h0, 32'h0, rd, e);
    chk("sh_01_low_half", rd, 32'h1234AAAA);
`endif

    access(1, 1, SZ_W, 32'h20, 32'hCAFEF00D, rd, e);
    access(1, 0, SZ_W, 32'h20, 32'h0, rd, e);
    chk("w0_lw_20", rd, 32'hCAFEF00D);
    access(1, 0, SZ_HU, 32'h22, 32'h0, rd, e);
    chk("w0_lhu_22", rd, 32'h0000CAFE);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
